// File: rtl/vx_dcache_rsp_split.sv
// Response buffer for the dcache core-response path: stores full-width responses
// in a small FIFO and replays each one as narrower lane packets to the LSU.
module vx_dcache_rsp_split #(
    parameter int NUM_REQS   = 4,
    parameter int OUT_REQS   = 2,
    parameter int WORD_SIZE  = 4,
    parameter int TAG_WIDTH  = 8,
    parameter int DEPTH      = 2,
    parameter int SKIP_EMPTY = 1,
    localparam int NUM_PKTS   = NUM_REQS / OUT_REQS,
    localparam int WORD_WIDTH = 8 * WORD_SIZE,
    localparam int PID_WIDTH  = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           rsp_in_valid,
    input  logic [NUM_REQS-1:0]            rsp_in_tmask,
    input  logic [NUM_REQS*WORD_WIDTH-1:0] rsp_in_data,
    input  logic [TAG_WIDTH-1:0]           rsp_in_tag,
    output logic                           rsp_in_ready,
    output logic                           rsp_out_valid,
    output logic [OUT_REQS-1:0]            rsp_out_tmask,
    output logic [OUT_REQS*WORD_WIDTH-1:0] rsp_out_data,
    output logic [TAG_WIDTH-1:0]           rsp_out_tag,
    output logic [PID_WIDTH-1:0]           rsp_out_pid,
    output logic                           rsp_out_eop,
    input  logic                           rsp_out_ready
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int IN_DW  = NUM_REQS * WORD_WIDTH;
    localparam int OUT_DW = OUT_REQS * WORD_WIDTH;

    logic [NUM_REQS-1:0]  tmask_mem_r [DEPTH];
    logic [IN_DW-1:0]     data_mem_r  [DEPTH];
    logic [TAG_WIDTH-1:0] tag_mem_r   [DEPTH];

    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;
    logic [PID_WIDTH-1:0] start_r;

    logic                 push_s;
    logic                 pop_s;
    logic                 fire_s;
    logic                 valid_s;
    logic [NUM_REQS-1:0]  head_tmask_s;
    logic [IN_DW-1:0]     head_data_s;
    logic [PID_WIDTH-1:0] pid_s;
    logic                 eop_s;
    logic [OUT_REQS-1:0]  chunk_tmask_s;
    logic [OUT_DW-1:0]    chunk_data_s;

    assign valid_s      = (count_r != CNT_W'(0));
    assign rsp_in_ready = (count_r != CNT_W'(DEPTH));
    assign push_s       = rsp_in_valid && rsp_in_ready;
    assign fire_s       = valid_s && rsp_out_ready;
    assign pop_s        = fire_s && eop_s;
    assign head_tmask_s = tmask_mem_r[rd_ptr_r];
    assign head_data_s  = data_mem_r[rd_ptr_r];

    // Select the packet to present and whether it closes out the head response.
    always_comb begin
        pid_s = '0;
        eop_s = 1'b1;
        if (SKIP_EMPTY != 0) begin
            // Descending scan leaves the lowest live chunk at or above start_r;
            // an all-empty mask falls through to pid 0 with eop so the tag still goes out.
            for (int k = NUM_PKTS - 1; k >= 0; k--) begin
                pid_s = ((k >= int'(start_r)) &&
                         (head_tmask_s[k*OUT_REQS +: OUT_REQS] != '0)) ? PID_WIDTH'(k) : pid_s;
            end
            for (int k = 0; k < NUM_PKTS; k++) begin
                eop_s = eop_s & ~((k > int'(pid_s)) &&
                                  (head_tmask_s[k*OUT_REQS +: OUT_REQS] != '0));
            end
        end else begin
            pid_s = start_r;
            eop_s = (start_r == PID_WIDTH'(NUM_PKTS - 1));
        end
    end

    // Lane mux for the selected chunk.
    always_comb begin
        chunk_tmask_s = '0;
        chunk_data_s  = '0;
        for (int k = 0; k < NUM_PKTS; k++) begin
            chunk_tmask_s = (pid_s == PID_WIDTH'(k)) ? head_tmask_s[k*OUT_REQS +: OUT_REQS] : chunk_tmask_s;
            chunk_data_s  = (pid_s == PID_WIDTH'(k)) ? head_data_s[k*OUT_DW +: OUT_DW] : chunk_data_s;
        end
    end

    assign rsp_out_valid = valid_s;
    assign rsp_out_tmask = valid_s ? chunk_tmask_s : '0;
    assign rsp_out_data  = chunk_data_s;
    assign rsp_out_tag   = tag_mem_r[rd_ptr_r];
    assign rsp_out_pid   = pid_s;
    assign rsp_out_eop   = eop_s;

    // FIFO storage write; contents are only observed while count_r is nonzero.
    always_ff @(posedge clk) begin
        if (push_s) begin
            tmask_mem_r[wr_ptr_r] <= rsp_in_tmask;
            data_mem_r[wr_ptr_r]  <= rsp_in_data;
            tag_mem_r[wr_ptr_r]   <= rsp_in_tag;
        end
    end

    // Pointers, occupancy and the per-response packet start index.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            start_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            if (pop_s) begin
                start_r <= '0;
            end else if (fire_s) begin
                start_r <= pid_s + PID_WIDTH'(1);
            end else begin
                start_r <= start_r;
            end
        end
    end

endmodule

// File: tb/tb_vx_dcache_rsp_split.sv
// Bench for vx_dcache_rsp_split: three configurations (skip / no-skip / degenerate),
// vector table, hand-written corner sequences and randomized scoreboard runs.
module tb_vx_dcache_rsp_split;

    localparam logic [127:0] DW = 128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000;
    localparam logic [127:0] LO = 128'hDDDD0001_DDDD0000;
    localparam logic [127:0] HI = 128'hDDDD0003_DDDD0002;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         i_valid  [3];
    logic [3:0]   i_tmask  [3];
    logic [127:0] i_data   [3];
    logic [7:0]   i_tag    [3];
    logic         i_oready [3];
    logic         o_iready [3];
    logic         o_valid  [3];
    logic [3:0]   o_tm     [3];
    logic [127:0] o_data   [3];
    logic [7:0]   o_tag    [3];
    logic         o_pid    [3];
    logic         o_eop    [3];

    logic [1:0]   d0_tm, d1_tm;
    logic [63:0]  d0_dat, d1_dat;
    logic [3:0]   d2_tm;
    logic [127:0] d2_dat;

    assign o_tm[0]   = {2'b00, d0_tm};
    assign o_tm[1]   = {2'b00, d1_tm};
    assign o_tm[2]   = d2_tm;
    assign o_data[0] = {64'd0, d0_dat};
    assign o_data[1] = {64'd0, d1_dat};
    assign o_data[2] = d2_dat;

    always #5 clk = ~clk;

    vx_dcache_rsp_split #(.OUT_REQS(2), .SKIP_EMPTY(1)) u_d0 (
        .clk(clk), .reset(reset),
        .rsp_in_valid(i_valid[0]), .rsp_in_tmask(i_tmask[0]), .rsp_in_data(i_data[0]),
        .rsp_in_tag(i_tag[0]), .rsp_in_ready(o_iready[0]),
        .rsp_out_valid(o_valid[0]), .rsp_out_tmask(d0_tm), .rsp_out_data(d0_dat),
        .rsp_out_tag(o_tag[0]), .rsp_out_pid(o_pid[0]), .rsp_out_eop(o_eop[0]),
        .rsp_out_ready(i_oready[0]));

    vx_dcache_rsp_split #(.OUT_REQS(2), .SKIP_EMPTY(0)) u_d1 (
        .clk(clk), .reset(reset),
        .rsp_in_valid(i_valid[1]), .rsp_in_tmask(i_tmask[1]), .rsp_in_data(i_data[1]),
        .rsp_in_tag(i_tag[1]), .rsp_in_ready(o_iready[1]),
        .rsp_out_valid(o_valid[1]), .rsp_out_tmask(d1_tm), .rsp_out_data(d1_dat),
        .rsp_out_tag(o_tag[1]), .rsp_out_pid(o_pid[1]), .rsp_out_eop(o_eop[1]),
        .rsp_out_ready(i_oready[1]));

    vx_dcache_rsp_split #(.OUT_REQS(4), .SKIP_EMPTY(1)) u_d2 (
        .clk(clk), .reset(reset),
        .rsp_in_valid(i_valid[2]), .rsp_in_tmask(i_tmask[2]), .rsp_in_data(i_data[2]),
        .rsp_in_tag(i_tag[2]), .rsp_in_ready(o_iready[2]),
        .rsp_out_valid(o_valid[2]), .rsp_out_tmask(d2_tm), .rsp_out_data(d2_dat),
        .rsp_out_tag(o_tag[2]), .rsp_out_pid(o_pid[2]), .rsp_out_eop(o_eop[2]),
        .rsp_out_ready(i_oready[2]));

    typedef struct {
        int           dut;
        logic [3:0]   tm;
        logic [7:0]   tag;
        int           npk;
        logic         pid0, pid1;
        logic [3:0]   tm0, tm1;
        logic [127:0] d0, d1;
        logic         eop0, eop1;
    } vec_t;

    typedef struct {
        logic         pid;
        logic [3:0]   tmask;
        logic [127:0] data;
        logic [7:0]   tag;
        logic         eop;
    } pkt_t;

    vec_t vecs [10];
    pkt_t mq [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_valid[i] = 1'b0; i_oready[i] = 1'b0;
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_pkt(input string nm, input int d, input logic pid, input logic [3:0] tm,
                           input logic [127:0] dat, input logic [7:0] tag, input logic eop);
        chk({nm, "_valid"}, 128'(o_valid[d]), 128'(1'b1));
        chk({nm, "_pid"},   128'(o_pid[d]),   128'(pid));
        chk({nm, "_tmask"}, 128'(o_tm[d]),    128'(tm));
        chk({nm, "_data"},  o_data[d],        dat);
        chk({nm, "_tag"},   128'(o_tag[d]),   128'(tag));
        chk({nm, "_eop"},   128'(o_eop[d]),   128'(eop));
    endtask

    // Spec-level expansion of one response into its expected packet list.
    function automatic void expand(input logic [3:0] tm, input logic [127:0] dat,
                                   input logic [7:0] tag, input int nout, input bit skip);
        int npk = 4 / nout;
        int last = -1;
        int cm;
        logic [127:0] m;
        pkt_t p;
        m = (nout == 4) ? '1 : ((128'd1 << (nout * 32)) - 128'd1);
        for (int k = 0; k < npk; k++) begin
            cm = (int'(tm) >> (k * nout)) & ((1 << nout) - 1);
            if (cm != 0) last = k;
        end
        for (int k = 0; k < npk; k++) begin
            cm = (int'(tm) >> (k * nout)) & ((1 << nout) - 1);
            if (!skip || cm != 0) begin
                p.pid   = 1'(k);
                p.tmask = 4'(cm);
                p.data  = (dat >> (k * nout * 32)) & m;
                p.tag   = tag;
                p.eop   = skip ? (k == last) : (k == npk - 1);
                mq.push_back(p);
            end
        end
        if (skip && last < 0) begin
            p.pid = 1'b0; p.tmask = 4'h0; p.data = dat & m; p.tag = tag; p.eop = 1'b1;
            mq.push_back(p);
        end
    endfunction

    task automatic run_random(input int idx, input int nresp, input int nout,
                              input bit skip, input bit toggle);
        int   cnt = 0;
        int   pushed = 0;
        int   cyc = 0;
        int   r;
        bit   oready = 1'b0;
        bit   mrdy;
        pkt_t p;
        mq.delete();
        while ((pushed < nresp || mq.size() != 0) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            r = $urandom_range(0, 7);
            i_valid[idx] = (pushed < nresp) && ($urandom_range(0, 3) != 0);
            i_tmask[idx] = (r == 0) ? 4'h0 : (r == 1) ? 4'hF : 4'($urandom_range(0, 15));
            i_data[idx]  = {$urandom(), $urandom(), $urandom(), $urandom()};
            i_tag[idx]   = 8'($urandom());
            oready       = toggle ? ~oready : ($urandom_range(0, 2) != 0);
            i_oready[idx] = oready;
            #1;
            chk("rnd_valid", 128'(o_valid[idx]), 128'(cnt != 0));
            chk("rnd_iready", 128'(o_iready[idx]), 128'(cnt != 2));
            if (cnt == 0) begin
                chk("rnd_tm_idle", 128'(o_tm[idx]), 128'(4'h0));
            end else begin
                p = mq[0];
                chk_pkt("rnd", idx, p.pid, p.tmask, p.data, p.tag, p.eop);
            end
            mrdy = (cnt != 2);
            if (cnt != 0 && oready) begin
                p = mq.pop_front();
                if (p.eop) cnt--;
            end
            if (i_valid[idx] && mrdy) begin
                expand(i_tmask[idx], i_data[idx], i_tag[idx], nout, skip);
                cnt++;
                pushed++;
            end
        end
        i_valid[idx] = 1'b0;
        i_oready[idx] = 1'b0;
        chk("rnd_all_pushed", 128'(pushed), 128'(nresp));
        chk("rnd_drained", 128'(mq.size()), 128'(0));
    endtask

    initial begin
        logic [7:0] exp_tags [3];
        int  got;
        bit  acc;

        for (int i = 0; i < 3; i++) begin
            i_valid[i] = 1'b0; i_tmask[i] = 4'h0; i_data[i] = 128'd0;
            i_tag[i] = 8'h00; i_oready[i] = 1'b0;
        end
        vecs[0] = '{0, 4'hF, 8'h5A, 2, 1'b0, 1'b1, 4'h3, 4'h3, LO, HI,   1'b0, 1'b1};
        vecs[1] = '{0, 4'hC, 8'h11, 1, 1'b1, 1'b0, 4'h3, 4'h0, HI, 128'd0, 1'b1, 1'b0};
        vecs[2] = '{1, 4'hC, 8'h22, 2, 1'b0, 1'b1, 4'h0, 4'h3, LO, HI,   1'b0, 1'b1};
        vecs[3] = '{0, 4'h0, 8'h33, 1, 1'b0, 1'b0, 4'h0, 4'h0, LO, 128'd0, 1'b1, 1'b0};
        vecs[4] = '{0, 4'h3, 8'h44, 1, 1'b0, 1'b0, 4'h3, 4'h0, LO, 128'd0, 1'b1, 1'b0};
        vecs[5] = '{0, 4'h6, 8'h45, 2, 1'b0, 1'b1, 4'h2, 4'h1, LO, HI,   1'b0, 1'b1};
        vecs[6] = '{2, 4'hA, 8'h55, 1, 1'b0, 1'b0, 4'hA, 4'h0, DW, 128'd0, 1'b1, 1'b0};
        vecs[7] = '{1, 4'h0, 8'h66, 2, 1'b0, 1'b1, 4'h0, 4'h0, LO, HI,   1'b0, 1'b1};
        vecs[8] = '{1, 4'hF, 8'h67, 2, 1'b0, 1'b1, 4'h3, 4'h3, LO, HI,   1'b0, 1'b1};
        vecs[9] = '{2, 4'h0, 8'h68, 1, 1'b0, 1'b0, 4'h0, 4'h0, DW, 128'd0, 1'b1, 1'b0};

        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset_valid", 128'(o_valid[i]), 128'(1'b0));
            chk("reset_iready", 128'(o_iready[i]), 128'(1'b1));
            chk("reset_tmask", 128'(o_tm[i]), 128'(4'h0));
        end

        // Vector table: one response each, consumer always ready.
        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            i_valid[vecs[v].dut]  = 1'b1;
            i_tmask[vecs[v].dut]  = vecs[v].tm;
            i_data[vecs[v].dut]   = DW;
            i_tag[vecs[v].dut]    = vecs[v].tag;
            i_oready[vecs[v].dut] = 1'b1;
            #1;
            chk("vec_idle", 128'(o_valid[vecs[v].dut]), 128'(1'b0));
            @(negedge clk);
            i_valid[vecs[v].dut] = 1'b0;
            #1;
            chk_pkt($sformatf("vec%0d_p0", v), vecs[v].dut, vecs[v].pid0, vecs[v].tm0,
                    vecs[v].d0, vecs[v].tag, vecs[v].eop0);
            if (vecs[v].npk == 2) begin
                @(negedge clk);
                #1;
                chk_pkt($sformatf("vec%0d_p1", v), vecs[v].dut, vecs[v].pid1, vecs[v].tm1,
                        vecs[v].d1, vecs[v].tag, vecs[v].eop1);
            end
            @(negedge clk);
            #1;
            chk($sformatf("vec%0d_empty", v), 128'(o_valid[vecs[v].dut]), 128'(1'b0));
            i_oready[vecs[v].dut] = 1'b0;
        end

        // Backpressure: three back-to-back pushes into a 2-deep FIFO.
        pulse_reset();
        exp_tags[0] = 8'hA1; exp_tags[1] = 8'hA2; exp_tags[2] = 8'hA3;
        @(negedge clk);
        i_oready[0] = 1'b0; i_valid[0] = 1'b1; i_tmask[0] = 4'hF; i_data[0] = DW; i_tag[0] = 8'hA1;
        @(negedge clk);
        i_tag[0] = 8'hA2;
        #1;
        chk("bp_ready1", 128'(o_iready[0]), 128'(1'b1));
        @(negedge clk);
        i_tag[0] = 8'hA3;
        #1;
        chk("bp_full", 128'(o_iready[0]), 128'(1'b0));
        @(negedge clk);
        #1;
        chk("bp_still_full", 128'(o_iready[0]), 128'(1'b0));
        chk_pkt("bp_frozen", 0, 1'b0, 4'h3, LO, 8'hA1, 1'b0);
        i_oready[0] = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            if (o_valid[0] && o_eop[0]) begin
                chk("bp_order", 128'(o_tag[0]), 128'(exp_tags[got]));
                got++;
            end
            acc = i_valid[0] && o_iready[0];
            @(negedge clk);
            if (acc) i_valid[0] = 1'b0;
            #1;
        end
        chk("bp_count", 128'(got), 128'(3));
        chk("bp_drained", 128'(o_valid[0]), 128'(1'b0));
        i_oready[0] = 1'b0;

        // Reset while the head sits on pid 1 not yet accepted.
        pulse_reset();
        @(negedge clk);
        i_valid[0] = 1'b1; i_tmask[0] = 4'hF; i_data[0] = DW; i_tag[0] = 8'h77;
        @(negedge clk);
        i_valid[0] = 1'b0; i_oready[0] = 1'b1;
        #1;
        chk_pkt("rst_p0", 0, 1'b0, 4'h3, LO, 8'h77, 1'b0);
        @(negedge clk);
        i_oready[0] = 1'b0;
        #1;
        chk_pkt("rst_p1", 0, 1'b1, 4'h3, HI, 8'h77, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_valid", 128'(o_valid[0]), 128'(1'b0));
        chk("rst_iready", 128'(o_iready[0]), 128'(1'b1));
        i_valid[0] = 1'b1; i_tag[0] = 8'h78; i_oready[0] = 1'b1;
        @(negedge clk);
        i_valid[0] = 1'b0;
        #1;
        chk_pkt("rst_new_p0", 0, 1'b0, 4'h3, LO, 8'h78, 1'b0);
        @(negedge clk);
        #1;
        chk_pkt("rst_new_p1", 0, 1'b1, 4'h3, HI, 8'h78, 1'b1);
        @(negedge clk);
        #1;
        chk("rst_new_empty", 128'(o_valid[0]), 128'(1'b0));
        i_oready[0] = 1'b0;

        // Randomized runs against the packet-list scoreboard.
        pulse_reset();
        run_random(0, 200, 2, 1'b1, 1'b0);
        pulse_reset();
        run_random(1, 150, 2, 1'b0, 1'b0);
        pulse_reset();
        run_random(2, 100, 4, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vx_dcache_rsp_split.md
Name: vx_dcache_rsp_split

Overview:
Parametrised response buffer and lane serializer for the dcache response path. It accepts NUM_REQS-lane dcache responses (valid/tmask/data/tag/ready) into a small FIFO. Each buffered response is replayed to a narrower consumer as OUT_REQS-lane packets, optionally skipping packets whose lanes are all inactive. It sits between the dcache core-response port and a narrow-issue LSU writeback stage.

Parameters:
NUM_REQS, 4, input lanes per response
OUT_REQS, 2, lanes per output packet; must divide NUM_REQS; NUM_PKTS = NUM_REQS/OUT_REQS
WORD_SIZE, 4, bytes per lane; WORD_WIDTH = 8*WORD_SIZE
TAG_WIDTH, 8, response tag width
DEPTH, 2, input FIFO entries; power of 2, >= 2
SKIP_EMPTY, 1, 1 = suppress packets whose lane mask is all zero

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
rsp_in_valid  in  1  input response valid
rsp_in_tmask  in  NUM_REQS  input lane mask
rsp_in_data  in  NUM_REQS*WORD_WIDTH  input lane data; lane i at bits [i*WORD_WIDTH +: WORD_WIDTH]
rsp_in_tag  in  TAG_WIDTH  input tag
rsp_in_ready  out  1  FIFO not full
rsp_out_valid  out  1  output packet valid
rsp_out_tmask  out  OUT_REQS  packet lane mask
rsp_out_data  out  OUT_REQS*WORD_WIDTH  packet lane data
rsp_out_tag  out  TAG_WIDTH  tag of the head response
rsp_out_pid  out  max(1,clog2(NUM_PKTS))  packet index within the response
rsp_out_eop  out  1  last packet of the response
rsp_out_ready  in  1  consumer accepts packet

Behaviour:
- One clock domain: clk. Synchronous active-high reset.
- Reset state: FIFO wr/rd pointers = 0, count = 0, start register = 0.
- Reset outputs: rsp_out_valid = 0, rsp_in_ready = 1.
- rsp_out_tmask is forced to 0 whenever rsp_out_valid = 0. Data, tag and pid are don't-care when rsp_out_valid = 0.
- Push: rsp_in_valid && rsp_in_ready. rsp_in_ready = (count != DEPTH). There is no same-cycle push-through when full.
- Pop: occurs only on the eop handshake (rsp_out_valid && rsp_out_ready && rsp_out_eop).
- Push and pop in the same cycle leaves count unchanged.
- Latency: a response pushed in cycle N appears at the output in cycle N+1 at the earliest. FIFO storage is registered; the output is combinational from the FIFO head and the start register.
- rsp_out_valid = (count != 0).
- Chunk k = head lanes [k*OUT_REQS +: OUT_REQS]; its mask bits are head_tmask[k*OUT_REQS +: OUT_REQS].
- SKIP_EMPTY = 1:
  - out pid = lowest k >= start whose chunk mask != 0.
  - eop = 1 when no chunk > pid has a nonzero mask.
- SKIP_EMPTY = 0: out pid = start; eop = (pid == NUM_PKTS-1).
- All-zero head tmask with SKIP_EMPTY = 1: emit exactly one packet with pid = 0, tmask = 0, eop = 1, so the tag is still delivered.
- Handshake updates:
  - Non-eop fire: start <= pid+1.
  - Eop fire: start <= 0 and pop.
  - No fire: start holds.
- Stall: while rsp_out_valid && !rsp_out_ready, all rsp_out_* stay stable. Inputs may still be pushed if the FIFO is not full.
- Order: responses leave in arrival order. Packets within a response leave in ascending pid order.
- Degenerate case OUT_REQS == NUM_REQS: pure FIFO; pid = 0; eop = 1 always (SKIP_EMPTY has no effect).
- Reset mid-response drops all buffered entries and partial progress. The next accepted response starts at pid 0.
- Implementation is a FIFO plus a start counter. Logical states:
  - EMPTY (count = 0) -> SEND on push.
  - SEND -> SEND on eop pop with count > 1, or on pop+push.
  - SEND -> EMPTY on eop pop with count = 1 and no push.

Test Plan:
- Defaults, push tmask=4'b1111, tag=0x5A, lanes D0..D3, out_ready=1 -> cycle+1: pid0, tmask 2'b11, data {D1,D0}, eop0; cycle+2: pid1, tmask 2'b11, data {D3,D2}, eop1, pop.
- tmask=4'b1100: SKIP_EMPTY=1 -> single packet pid1, tmask 2'b11, eop1. SKIP_EMPTY=0 -> pid0 tmask 2'b00 eop0, then pid1 tmask 2'b11 eop1.
- tmask=4'b0000, tag=0x33 (SKIP_EMPTY=1) -> one packet pid0, tmask 2'b00, tag 0x33, eop1. FIFO empty the next cycle.
- Backpressure: out_ready=0, push 3 back-to-back responses with DEPTH=2 -> two accepted, rsp_in_ready=0 thereafter, outputs frozen on pid0. Release out_ready -> tags leave in order and the third response is then accepted.
- Reset asserted while the head is at pid1 not yet fired -> next cycle rsp_out_valid=0, rsp_in_ready=1, count=0. The following push emits from pid0.
- OUT_REQS=NUM_REQS=4, 1-cycle pushes with out_ready toggling 1/0 -> every packet has eop=1 and pid=0. No loss or duplication over 100 random responses, checked against a scoreboard.
